// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared opcodes, FSM state encodings and flag bit positions for
//            the accumulator-side ALU stage, plus a flag-packing helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Opcodes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Bit positions inside the 4-bit {C,V,N,Z} flag vector
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic n, input logic z);
    logic [3:0] f;
    f        = 4'b0000;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module  : alu_mul_seq
//  Purpose : Unsigned shift-and-add multiplier, one multiplier bit per clock.
//            Used only when ALU_MUL_EN is defined.
//  Ports   : clk, rst_n          clock / async active-low reset
//            go                  load a, b and start (one-cycle pulse)
//            a, b   [WIDTH]      operands, sampled on the go edge
//            product[2*WIDTH]    full product, valid while fin is high
//            fin                 one-cycle pulse: product valid this cycle
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               fin
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic               r_fin;

  // Always runs exactly WIDTH iterations, so latency does not depend on
  // the operand values (a zero multiplier still walks every bit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (go) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (r_cnt == C_LAST) begin
          r_run <= 1'b0;
          r_fin <= 1'b1;
        end
      end
    end
  end

  assign product = r_acc;
  assign fin     = r_fin;

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
//  Module  : alu_unit
//  Purpose : ALU stage feeding the accumulator. Latches operands on an
//            accepted start, computes the result, registers result + {C,V,N,Z}
//            flags and pulses done for one cycle.
//  Config  : ALU_MUL_EN - when defined, op 7 runs the sequential multiplier
//            (WIDTH+1 cycle latency). When undefined, op 7 completes in one
//            cycle with result 0, Z=1 and sets the sticky illegal flag.
//  Ports   : clk, rst_n        clock / async active-low reset
//            start, op[3]      request + opcode (sampled only in IDLE)
//            a_in, b_in        operands
//            busy, done        status / one-cycle completion pulse
//            result, flags     registered result and {C,V,N,Z}
//            illegal           sticky: MUL issued without multiplier
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;

  logic             w_accept;
  logic             w_illegal_req;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_product;
  logic               w_mul_fin;
  logic               w_mul_go;

  // The multiplier loads straight from the ports on the accept edge so its
  // first iteration lands on the very next clock.
  assign w_mul_go      = w_accept && (op == OP_MUL);
  assign w_illegal_req = 1'b0;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (w_mul_go),
    .a       (a_in),
    .b       (b_in),
    .product (w_product),
    .fin     (w_mul_fin)
  );
`else
  assign w_illegal_req = (op == OP_MUL);
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          w_next_state = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          w_next_state = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next_state = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (w_mul_fin) w_next_state = S_DONE;
`else
      S_MUL:  w_next_state = S_IDLE;
`endif
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Operand latch: later changes on a_in/b_in/op are ignored until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= a_in;
      r_b  <= b_in;
    end
  end

  // Extra top bit of the sum is the carry; of the difference it is the
  // borrow (a < b unsigned).
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Single-cycle datapath. OP_MUL only reaches here without the multiplier
  // and yields zero.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: {w_c, w_res} = {r_a, 1'b0};
      OP_SHR: {w_res, w_c} = {1'b0, r_a};
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
  end

  // Result / flag registers: updated only on the cycle that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else if (r_state == S_EXEC) begin
      r_result <= w_res;
      r_flags  <= pack_flags(w_c, w_v, w_res[WIDTH-1], (w_res == '0));
`ifdef ALU_MUL_EN
    end else if ((r_state == S_MUL) && w_mul_fin) begin
      r_result <= w_product[WIDTH-1:0];
      r_flags  <= pack_flags(|w_product[2*WIDTH-1:WIDTH], 1'b0,
                             w_product[WIDTH-1],
                             (w_product[WIDTH-1:0] == '0));
`endif
    end
  end

  // Sticky illegal flag: re-evaluated on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= w_illegal_req;
    end
  end

  assign result  = r_result;
  assign flags   = r_flags;
  assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
// ============================================================================
//  Module  : tb_alu_unit
//  Purpose : Self-checking bench for alu_unit (WIDTH=8). Expected results are
//            produced by an arithmetic model when an op is issued, queued, and
//            compared when done is observed.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_unit;

  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         illegal;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {flags[3:0], result[7:0]}
  logic [11:0] sb[$];

  alu_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model using integer arithmetic; flags packed as {C,V,N,Z}.
  function automatic logic [11:0] model(input logic [2:0] m_op,
                                        input logic [7:0] ma,
                                        input logic [7:0] mb);
    int       ua, ub, sa, sb_i, full, sres;
    logic [7:0] r;
    logic     c, v;
    ua = int'(ma); ub = int'(mb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb_i = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (m_op)
      3'd0: begin full = ua + ub; r = full[7:0]; c = (full > 255);
                  sres = sa + sb_i; v = (sres > 127) || (sres < -128); end
      3'd1: begin full = ua - ub + 256; r = full[7:0]; c = (ua < ub);
                  sres = sa - sb_i; v = (sres > 127) || (sres < -128); end
      3'd2: r = ma & mb;
      3'd3: r = ma | mb;
      3'd4: r = ma ^ mb;
      3'd5: begin full = ua * 2; r = full[7:0]; c = (full > 255); end
      3'd6: begin r = 8'(ua / 2); c = (ua % 2) == 1; end
      default: begin
`ifdef ALU_MUL_EN
        full = ua * ub; r = full[7:0]; c = (full > 255);
`else
        r = 8'h00;
`endif
      end
    endcase
    return {c, v, r[7], (r == 8'h00), r};
  endfunction

  // Issue one op, wait (bounded) for done, compare against the scoreboard.
  // inject: pulse an ADD start two cycles into the op; it must be ignored.
  task automatic run_op(input string tag, input logic [2:0] t_op,
                        input logic [7:0] t_a, input logic [7:0] t_b,
                        input int exp_lat, input bit inject);
    int cycles;
    int extra;
    logic [11:0] exp;
    @(negedge clk);
    start = 1'b1; op = t_op; a_in = t_a; b_in = t_b;
    sb.push_back(model(t_op, t_a, t_b));
    @(posedge clk); #1;
    start = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); op = 3'($urandom);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (inject && cycles == 2) begin
        start = 1'b1; op = 3'd0; a_in = 8'h11; b_in = 8'h22;
      end
      if (inject && cycles == 3) start = 1'b0;
    end while (!done && cycles < 40);
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, cycles, exp_lat);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_result"}, {24'd0, result}, {24'd0, exp[7:0]});
      check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp[11:8]});
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    if (inject) begin
      extra = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_no_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_result",  {24'd0, result},  32'd0);
    check("rst_flags",   {28'd0, flags},   32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 1, 1'b0);
    run_op("sub_80_01", 3'd1, 8'h80, 8'h01, 1, 1'b0);
    run_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 1, 1'b0);
    run_op("shl_81",    3'd5, 8'h81, 8'h00, 1, 1'b0);
    run_op("shr_81",    3'd6, 8'h81, 8'h00, 1, 1'b0);
    run_op("sub_00_01", 3'd1, 8'h00, 8'h01, 1, 1'b0);
    run_op("and",       3'd2, 8'hF0, 8'h3C, 1, 1'b0);
    run_op("or",        3'd3, 8'hA0, 8'h05, 1, 1'b0);
    run_op("xor_zero",  3'd4, 8'h5A, 8'h5A, 1, 1'b0);

`ifdef ALU_MUL_EN
    run_op("mul_0c_0a", 3'd7, 8'h0C, 8'h0A, MUL_LAT, 1'b0);
    run_op("mul_ff_ff", 3'd7, 8'hFF, 8'hFF, MUL_LAT, 1'b0);
    run_op("mul_zero",  3'd7, 8'h00, 8'h37, MUL_LAT, 1'b0);
    run_op("mul_busy",  3'd7, 8'h13, 8'h07, MUL_LAT, 1'b1);
    check("mul_illegal", {31'd0, illegal}, 32'd0);
`else
    run_op("mul_nomul", 3'd7, 8'h0C, 8'h0A, MUL_LAT, 1'b0);
    check("nomul_illegal_set", {31'd0, illegal}, 32'd1);
    run_op("add_clr",   3'd0, 8'h01, 8'h02, 1, 1'b0);
    check("nomul_illegal_clr", {31'd0, illegal}, 32'd0);
`endif

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a_in = 8'h0C; b_in = 8'h0A;
`ifdef ALU_MUL_EN
    op = 3'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
`else
    op = 3'd0;
    @(posedge clk); #1; start = 1'b0;
`endif
    #2;
    check("midop_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy},   32'd0);
    check("arst_done",   {31'd0, done},   32'd0);
    check("arst_result", {24'd0, result}, 32'd0);
    check("arst_flags",  {28'd0, flags},  32'd0);
    @(negedge clk); rst_n = 1'b1;

`ifdef ALU_MUL_EN
    run_op("post_rst_mul", 3'd7, 8'h0C, 8'h0A, MUL_LAT, 1'b0);
`else
    run_op("post_rst_add", 3'd0, 8'h40, 8'h40, 1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
